// File: rtl/ff_bank_pkg.sv
// rtl/ff_bank_pkg.sv - shared mode encodings and JK next-state helper for ff_bank_prescaled
package ff_bank_pkg;

   localparam logic [1:0] MODE_T    = 2'b00;
   localparam logic [1:0] MODE_D    = 2'b01;
   localparam logic [1:0] MODE_JK   = 2'b10;
   localparam logic [1:0] MODE_HOLD = 2'b11;

   // JK truth table: 00 hold, 01 clear, 10 set, 11 toggle
   function automatic logic jk_next(input logic q, input logic j, input logic k);
      logic r;
      case ({j, k})
         2'b00:   r = q;
         2'b01:   r = 1'b0;
         2'b10:   r = 1'b1;
         default: r = ~q;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ff_bank_prescaled_tick_gen.sv
// rtl/ff_bank_prescaled_tick_gen.sv - free-running prescaler producing a one-cycle registered update strobe
module tick_gen #(
   parameter int DIV_BITS = 24
) (
   input  logic clk,
   input  logic rst,
   input  logic bypass,
   output logic tick
);

   logic [DIV_BITS-1:0] cnt_q;
   logic [DIV_BITS-1:0] cnt_d;
   logic                tick_q;
   logic                tick_d;

   // Counter wraps by natural overflow; bypass forces the strobe but never stalls the count
   always_comb begin
      cnt_d  = cnt_q + DIV_BITS'(1);
      tick_d = (cnt_q == '1) | bypass;
   end

   // Counter and strobe registers; reset discards any pending tick
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/ff_bank_prescaled.sv
// rtl/ff_bank_prescaled.sv - bank of T/D/JK flip-flop channels clock-enabled by a prescaler tick
module ff_bank_prescaled
   import ff_bank_pkg::*;
#(
   parameter int WIDTH       = 4,
   parameter int DIV_BITS    = 24,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             tick_bypass,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qb,
   output logic             tick
);

   logic tick_w;

   tick_gen #(
      .DIV_BITS(DIV_BITS)
   ) u_tick_gen (
      .clk   (clk),
      .rst   (rst),
      .bypass(tick_bypass),
      .tick  (tick_w)
   );

   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      logic [SYNC_STAGES-1:0] a_sync_q;
      logic [SYNC_STAGES-1:0] b_sync_q;
      logic                   a_s;
      logic                   b_s;
      logic                   ch_q;
      logic                   ch_d;

      // Shift raw switch/button levels through the synchroniser chain
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            a_sync_q <= '0;
            b_sync_q <= '0;
         end else begin
            a_sync_q <= {a_sync_q[SYNC_STAGES-2:0], a[i]};
            b_sync_q <= {b_sync_q[SYNC_STAGES-2:0], b[i]};
         end
      end

      assign a_s = a_sync_q[SYNC_STAGES-1];
      assign b_s = b_sync_q[SYNC_STAGES-1];

      // Next state: load wins over the tick; otherwise the mode acts only on tick edges
      always_comb begin
         ch_d = ch_q;
         if (load) begin
            ch_d = load_val[i];
         end else if (tick_w) begin
            case (mode)
               MODE_T:  ch_d = ch_q ^ a_s;
               MODE_D:  ch_d = a_s;
               MODE_JK: ch_d = jk_next(ch_q, a_s, b_s);
               default: ch_d = ch_q;
            endcase
         end
      end

      // Channel state register
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            ch_q <= 1'b0;
         end else begin
            ch_q <= ch_d;
         end
      end

      assign q[i] = ch_q;
   end

   assign qb   = ~q;
   assign tick = tick_w;

endmodule

// File: tb/tb_ff_bank_prescaled.sv
// tb/tb_ff_bank_prescaled.sv - scoreboard bench for ff_bank_prescaled with directed vectors
module tb_ff_bank_prescaled;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] mode;
   logic [3:0] a;
   logic [3:0] b;
   logic       tick_bypass;
   logic       load;
   logic [3:0] load_val;
   logic [3:0] q;
   logic [3:0] qb;
   logic       tick;

   int n_checks = 0;
   int n_fail   = 0;

   logic [3:0] exp_q [$];
   logic [3:0] exp_cur = 4'h0;
   logic [3:0] mon_exp;
   logic [3:0] mon_inv;
   logic       mon_en = 1'b0;
   logic       tick_at_edge = 1'b0;
   logic       load_at_edge = 1'b0;

   ff_bank_prescaled #(
      .WIDTH      (4),
      .DIV_BITS   (3),
      .SYNC_STAGES(2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .mode       (mode),
      .a          (a),
      .b          (b),
      .tick_bypass(tick_bypass),
      .load       (load),
      .load_val   (load_val),
      .q          (q),
      .qb         (qb),
      .tick       (tick)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b at %0t", name, act, expv, $time);
      end
   endtask

   task automatic wait_tick();
      int n;
      n = 0;
      @(negedge clk);
      while (tick !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (tick !== 1'b1) begin
         n_checks++;
         n_fail++;
         $display("FAIL tick_timeout: got no tick, expected one within 20 cycles at %0t", $time);
      end
   endtask

   // Record what the DUT saw at each active edge
   always @(posedge clk) begin
      tick_at_edge <= tick;
      load_at_edge <= load;
   end

   // Monitor: every tick-driven update pops one expectation; other edges must hold q
   always @(negedge clk) begin
      if (mon_en) begin
         if (tick_at_edge) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL sb_underflow: got update q=%b, expected none queued at %0t", q, $time);
            end else begin
               mon_exp = exp_q.pop_front();
               mon_inv = ~mon_exp;
               check("sb_q", q, mon_exp);
               check("sb_qb", qb, mon_inv);
               exp_cur = mon_exp;
            end
         end else if (!load_at_edge) begin
            check("between_ticks_q", q, exp_cur);
         end
      end
   end

   initial begin
      rst = 1'b0; mode = 2'b11; a = 4'h0; b = 4'h0;
      tick_bypass = 1'b0; load = 1'b0; load_val = 4'h0;

      // Reset state
      #12;
      check("reset_q", q, 4'b0000);
      check("reset_qb", qb, 4'b1111);
      check("reset_tick", {3'b0, tick}, 4'h0);
      exp_q.push_back(4'b0000);
      exp_q.push_back(4'b0000);
      mon_en = 1'b1;
      #10 rst = 1'b1;

      // Prescaler: tick only on cycles 8 and 16
      for (int c = 1; c <= 16; c++) begin
         @(posedge clk);
         @(negedge clk);
         check($sformatf("tick_cyc%0d", c), {3'b0, tick}, {3'b0, (c == 8 || c == 16)});
      end
      @(negedge clk);

      // T mode toggling
      mode = 2'b00; a = 4'b1010;
      exp_q.push_back(4'b1010);
      exp_q.push_back(4'b0000);
      exp_q.push_back(4'b1010);
      repeat (3) wait_tick();
      @(negedge clk);

      // JK mode truth table
      mode = 2'b10; a = 4'b1111; b = 4'b0000;
      exp_q.push_back(4'b1111);
      wait_tick(); @(negedge clk);
      a = 4'b0000; b = 4'b0101;
      exp_q.push_back(4'b1010);
      wait_tick(); @(negedge clk);
      a = 4'b1111; b = 4'b1111;
      exp_q.push_back(4'b0101);
      wait_tick(); @(negedge clk);
      a = 4'b0000; b = 4'b0000;
      exp_q.push_back(4'b0101);
      wait_tick(); @(negedge clk);

      // Load on a tick edge consumes the tick; next tick toggles the loaded value
      mode = 2'b00; a = 4'b1111;
      exp_q.push_back(4'b0110);
      exp_q.push_back(4'b1001);
      wait_tick();
      load = 1'b1; load_val = 4'b0110;
      @(posedge clk); #1 load = 1'b0;
      wait_tick(); @(negedge clk);

      // Load between ticks takes effect in one cycle
      @(posedge clk); #1 mode = 2'b11; mon_en = 1'b0;
      load = 1'b1; load_val = 4'b0011;
      @(posedge clk); #1 load = 1'b0;
      @(negedge clk);
      check("load_offtick_q", q, 4'b0011);
      @(posedge clk); #1 exp_cur = 4'b0011; mon_en = 1'b1;
      exp_q.push_back(4'b0011);
      wait_tick(); @(negedge clk);

      // D mode with bypass: one-cycle pulse on a[0] appears 3 edges later
      @(posedge clk); #1 mon_en = 1'b0; mode = 2'b01; a = 4'b0000; tick_bypass = 1'b1;
      repeat (4) @(posedge clk);
      #1 a = 4'b0001;
      @(posedge clk); #1 a = 4'b0000;
      @(negedge clk); check("d_pulse_e1", q, 4'b0000);
      @(negedge clk); check("d_pulse_e2", q, 4'b0000);
      @(negedge clk); check("d_pulse_e3", q, 4'b0001);
      @(negedge clk); check("d_pulse_e4", q, 4'b0000);

      // Reset mid-period with q=1111 and cnt=5
      @(posedge clk); #1 tick_bypass = 1'b0; mode = 2'b11;
      repeat (2) @(posedge clk);
      wait_tick();
      load = 1'b1; load_val = 4'b1111;
      @(posedge clk); #1 load = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      check("pre_rst_q", q, 4'b1111);
      rst = 1'b0;
      #1;
      check("async_rst_q", q, 4'b0000);
      check("async_rst_qb", qb, 4'b1111);
      check("async_rst_tick", {3'b0, tick}, 4'h0);
      @(negedge clk);
      rst = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         check($sformatf("post_rst_tick_cyc%0d", c), {3'b0, tick}, {3'b0, (c == 8)});
      end

      check("sb_drained", exp_q.size() == 0 ? 4'h0 : 4'h1, 4'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
